// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the execute-stage sequencer.
//   - funct codes accepted on the request interface
//   - alu32 operation encodings
//   - sequencer FSM state enum
//   - alu_ctrl_t: decoded control bundle produced by alu_funct_decode
package alu_pkg;

  localparam logic [3:0] FUNCT_AND = 4'b0000;
  localparam logic [3:0] FUNCT_OR  = 4'b0001;
  localparam logic [3:0] FUNCT_ADD = 4'b0010;
  localparam logic [3:0] FUNCT_SUB = 4'b0110;
  localparam logic [3:0] FUNCT_SLT = 4'b0111;
  localparam logic [3:0] FUNCT_NOR = 4'b1100;

  localparam logic [1:0] ALU_OP_AND  = 2'b00;
  localparam logic [1:0] ALU_OP_OR   = 2'b01;
  localparam logic [1:0] ALU_OP_ADD  = 2'b10;
  localparam logic [1:0] ALU_OP_LESS = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_SLT2 = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  typedef struct packed {
    logic       ainv;
    logic       binv;
    logic       cin;
    logic [1:0] op;
    logic       is_slt;
    logic       is_arith;
    logic       illegal;
  } alu_ctrl_t;

endpackage

// File: rtl/alu_funct_decode.sv
// alu_funct_decode: combinational funct -> alu32 control decode.
// Ports:
//   funct     in  4  request function code
//   ainv      out 1  alu32 A_invert
//   binv      out 1  alu32 B_invert
//   cin       out 1  alu32 carry in
//   op        out 2  alu32 operation select
//   is_slt    out 1  set-less-than (two-pass) request
//   is_arith  out 1  ADD/SUB: overflow and carry are reported
//   illegal   out 1  unsupported funct code
module alu_funct_decode
  import alu_pkg::*;
(
  input  logic [3:0] funct,
  output logic       ainv,
  output logic       binv,
  output logic       cin,
  output logic [1:0] op,
  output logic       is_slt,
  output logic       is_arith,
  output logic       illegal
);

  always_comb begin
    ainv     = 1'b0;
    binv     = 1'b0;
    cin      = 1'b0;
    op       = ALU_OP_AND;
    is_slt   = 1'b0;
    is_arith = 1'b0;
    illegal  = 1'b0;
    case (funct)
      FUNCT_AND: op = ALU_OP_AND;
      FUNCT_OR:  op = ALU_OP_OR;
      FUNCT_ADD: begin
        op       = ALU_OP_ADD;
        is_arith = 1'b1;
      end
      FUNCT_SUB: begin
        binv     = 1'b1;
        cin      = 1'b1;
        op       = ALU_OP_ADD;
        is_arith = 1'b1;
      end
      // First SLT pass is a plain subtraction; the LESS pass is set up later.
      FUNCT_SLT: begin
        binv   = 1'b1;
        cin    = 1'b1;
        op     = ALU_OP_ADD;
        is_slt = 1'b1;
      end
      // NOR via De Morgan: ~a & ~b.
      FUNCT_NOR: begin
        ainv = 1'b1;
        binv = 1'b1;
        op   = ALU_OP_AND;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_exec_seq.sv
// alu_exec_seq: execute-stage sequencer driving an external alu32.
// Accepts one request over valid/ready, drives alu32 operands/controls from
// registers, runs SLT as a SUB pass followed by a LESS pass, and holds the
// captured result/flags until the consumer takes them.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   in_valid/in_ready                 request handshake
//   in_funct, in_src1, in_src2        request function and operands
//   alu_src1, alu_src2                registered operands to alu32
//   alu_ainv, alu_binv, alu_cin       registered alu32 controls
//   alu_op, alu_less                  registered alu32 operation / less input
//   alu_result, alu_cout              combinational alu32 outputs
//   out_valid/out_ready               result handshake
//   out_result, out_zero, out_ovf,
//   out_cout, out_err                 captured result and flags
module alu_exec_seq
  import alu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter bit SLT_SIGNED = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_funct,
  input  logic [WIDTH-1:0] in_src1,
  input  logic [WIDTH-1:0] in_src2,
  output logic [WIDTH-1:0] alu_src1,
  output logic [WIDTH-1:0] alu_src2,
  output logic             alu_ainv,
  output logic             alu_binv,
  output logic             alu_cin,
  output logic [1:0]       alu_op,
  output logic             alu_less,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_ovf,
  output logic             out_cout,
  output logic             out_err
);

  if (WIDTH != 32) begin : g_width_check
    $error("alu_exec_seq: only WIDTH=32 is supported");
  end

  state_t    state, state_nxt;
  alu_ctrl_t dec;
  logic      is_slt_q;
  logic      is_arith_q;
  logic      accept;
  logic      pass_ovf;
  logic      pass_less;

  // Signed overflow of the current alu32 add, using the effective operand signs.
  function automatic logic ovf_calc(input logic s1_msb, input logic s2_msb,
                                    input logic ainv, input logic binv,
                                    input logic res_msb);
    logic a;
    logic b;
    a = s1_msb ^ ainv;
    b = s2_msb ^ binv;
    return (a == b) && (res_msb != a);
  endfunction

  // Less bit from the SUB pass: signed compare corrects the sign with overflow,
  // unsigned compare is "no carry out" (borrow).
  function automatic logic less_calc(input logic diff_msb, input logic ovf,
                                     input logic cout);
    if (SLT_SIGNED)
      return diff_msb ^ ovf;
    else
      return ~cout;
  endfunction

  alu_funct_decode u_decode (
    .funct    (in_funct),
    .ainv     (dec.ainv),
    .binv     (dec.binv),
    .cin      (dec.cin),
    .op       (dec.op),
    .is_slt   (dec.is_slt),
    .is_arith (dec.is_arith),
    .illegal  (dec.illegal)
  );

  assign in_ready  = (state == ST_IDLE) && !rst;
  assign out_valid = (state == ST_DONE);
  assign accept    = in_valid && in_ready;

  assign pass_ovf  = ovf_calc(alu_src1[WIDTH-1], alu_src2[WIDTH-1],
                              alu_ainv, alu_binv, alu_result[WIDTH-1]);
  assign pass_less = less_calc(alu_result[WIDTH-1], pass_ovf, alu_cout);

  always_ff @(posedge clk) begin
    if (rst)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = dec.illegal ? ST_DONE : ST_EXEC;
      ST_EXEC: state_nxt = is_slt_q ? ST_SLT2 : ST_DONE;
      ST_SLT2: state_nxt = ST_DONE;
      ST_DONE: if (out_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_src1   <= '0;
      alu_src2   <= '0;
      alu_ainv   <= 1'b0;
      alu_binv   <= 1'b0;
      alu_cin    <= 1'b0;
      alu_op     <= ALU_OP_AND;
      alu_less   <= 1'b0;
      is_slt_q   <= 1'b0;
      is_arith_q <= 1'b0;
      out_result <= '0;
      out_zero   <= 1'b0;
      out_ovf    <= 1'b0;
      out_cout   <= 1'b0;
      out_err    <= 1'b0;
    end else begin
      case (state)
        // Request capture: operands and decoded controls go straight to alu32.
        ST_IDLE: begin
          if (accept) begin
            is_slt_q   <= dec.is_slt;
            is_arith_q <= dec.is_arith;
            if (dec.illegal) begin
              // No ALU pass: report the error directly.
              out_result <= '0;
              out_zero   <= 1'b0;
              out_ovf    <= 1'b0;
              out_cout   <= 1'b0;
              out_err    <= 1'b1;
            end else begin
              alu_src1 <= in_src1;
              alu_src2 <= in_src2;
              alu_ainv <= dec.ainv;
              alu_binv <= dec.binv;
              alu_cin  <= dec.cin;
              alu_op   <= dec.op;
              alu_less <= 1'b0;
            end
          end
        end
        // First pass result settles; SLT feeds its less bit into the second pass.
        ST_EXEC: begin
          if (is_slt_q) begin
            alu_op   <= ALU_OP_LESS;
            alu_less <= pass_less;
          end else begin
            out_result <= alu_result;
            out_zero   <= (alu_result == '0);
            out_ovf    <= is_arith_q && pass_ovf;
            out_cout   <= is_arith_q && alu_cout;
            out_err    <= 1'b0;
          end
        end
        // Second SLT pass: result is {0..0, less}; carry is whatever alu32 reports.
        ST_SLT2: begin
          out_result <= alu_result;
          out_zero   <= (alu_result == '0);
          out_ovf    <= 1'b0;
          out_cout   <= alu_cout;
          out_err    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
